// File: rtl/clk_probe_unit.sv
// Clocking-wizard / virtual-I/O stand-in: lock indication, divided clock-enable,
// a sampled result-bus capture with activity tracking, and a host register port.
module clk_probe_unit #(
  parameter int          DIV         = 2,
  parameter int          LOCK_CYCLES = 16,
  parameter logic [31:0] INIT_OUT    = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_locked,
  output logic        w_ce,
  input  logic [31:0] w_probe_in0,
  output logic [31:0] w_probe_out0,
  input  logic        w_host_rd,
  input  logic        w_host_wr,
  input  logic [1:0]  w_host_addr,
  input  logic [31:0] w_host_wdata,
  output logic [31:0] w_host_rdata,
  output logic        w_host_ack
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [31:0]   cap_q, cap_d;
  logic [31:0]   act_q, act_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   probe_out_q, probe_out_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          ce;
  logic [31:0]   rd_mux;

  assign ce = locked_q && (div_cnt_q == DIV_LAST);

  always_comb begin
    rd_mux = act_q;
    case (w_host_addr)
      2'd0:    rd_mux = cap_q;
      2'd1:    rd_mux = probe_out_q;
      2'd2:    rd_mux = {locked_q, 15'b0, cnt_q};
      default: rd_mux = act_q;
    endcase
  end

  // The previous-sample word is not host-visible, so only cap is kept; act
  // already accumulates every sample-to-sample difference.
  always_comb begin
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    div_cnt_d   = '0;
    cap_d       = cap_q;
    cnt_d       = cnt_q;
    probe_out_d = probe_out_q;
    rdata_d     = rdata_q;
    ack_d       = w_host_rd | w_host_wr;

    if (!locked_q) begin
      if (lock_cnt_q == LOCK_LAST) locked_d = 1'b1;
      else                         lock_cnt_d = lock_cnt_q + LW'(1);
    end

    if (locked_q) div_cnt_d = ce ? '0 : div_cnt_q + DW'(1);

    if (ce) begin
      cap_d = w_probe_in0;
      cnt_d = cnt_q + 16'd1;
    end

    // Clear-on-read is applied first so bits set by a colliding capture survive.
    act_d = ((w_host_rd && w_host_addr == 2'd3) ? 32'h0 : act_q)
          | (ce ? (w_probe_in0 ^ cap_q) : 32'h0);

    if (w_host_rd) rdata_d = rd_mux;
    if (w_host_wr && w_host_addr == 2'd1) probe_out_d = w_host_wdata;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      div_cnt_q   <= '0;
      cap_q       <= 32'h0;
      act_q       <= 32'h0;
      cnt_q       <= 16'h0;
      probe_out_q <= INIT_OUT;
      rdata_q     <= 32'h0;
      ack_q       <= 1'b0;
    end else begin
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      div_cnt_q   <= div_cnt_d;
      cap_q       <= cap_d;
      act_q       <= act_d;
      cnt_q       <= cnt_d;
      probe_out_q <= probe_out_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
    end
  end

  assign w_locked     = locked_q;
  assign w_ce         = ce;
  assign w_probe_out0 = probe_out_q;
  assign w_host_rdata = rdata_q;
  assign w_host_ack   = ack_q;

endmodule

// File: tb/tb_clk_probe_unit.sv
// Bench for clk_probe_unit: a DIV=4 instance checked every cycle against a
// behavioural model, plus a DIV=1 instance used for the 16-bit counter wrap.
module tb_clk_probe_unit;

  localparam int          L    = 16;
  localparam int          D    = 4;
  localparam logic [31:0] INIT = 32'hC0DE_0001;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DIV=4 instance
  logic        rst, locked, ce, host_rd, host_wr, ack;
  logic [1:0]  host_addr;
  logic [31:0] probe_in, probe_out, host_wdata, rdata;
  // DIV=1 instance
  logic        b_rst, b_locked, b_ce, b_rd, b_wr, b_ack;
  logic [1:0]  b_addr;
  logic [31:0] b_probe_in, b_probe_out, b_wdata, b_rdata;

  clk_probe_unit #(.DIV(D), .LOCK_CYCLES(L), .INIT_OUT(INIT)) dut (
    .w_clk(clk), .w_rst(rst), .w_locked(locked), .w_ce(ce),
    .w_probe_in0(probe_in), .w_probe_out0(probe_out),
    .w_host_rd(host_rd), .w_host_wr(host_wr), .w_host_addr(host_addr),
    .w_host_wdata(host_wdata), .w_host_rdata(rdata), .w_host_ack(ack)
  );

  clk_probe_unit #(.DIV(1), .LOCK_CYCLES(L), .INIT_OUT(32'h0)) dut1 (
    .w_clk(clk), .w_rst(b_rst), .w_locked(b_locked), .w_ce(b_ce),
    .w_probe_in0(b_probe_in), .w_probe_out0(b_probe_out),
    .w_host_rd(b_rd), .w_host_wr(b_wr), .w_host_addr(b_addr),
    .w_host_wdata(b_wdata), .w_host_rdata(b_rdata), .w_host_ack(b_ack)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: m_n counts non-reset edges since the last reset edge;
  // lock and enable follow from it arithmetically.
  int          m_n = 0;
  logic [31:0] m_cap = 0, m_act = 0, m_pout = INIT, m_rdata = 0;
  logic [15:0] m_cnt = 0;
  logic        m_ack = 0;

  function automatic logic m_locked();
    return m_n >= L;
  endfunction

  function automatic logic m_ce();
    return m_locked() && (((m_n - L) % D) == D - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    logic        lk, c;
    logic [31:0] rv;
    lk = m_locked();
    c  = m_ce();
    case (host_addr)
      2'd0:    rv = m_cap;
      2'd1:    rv = m_pout;
      2'd2:    rv = {lk, 15'b0, m_cnt};
      default: rv = m_act;
    endcase
    @(posedge clk);
    #1;
    if (rst) begin
      m_n = 0; m_cap = 0; m_act = 0; m_cnt = 0;
      m_pout = INIT; m_rdata = 0; m_ack = 0;
    end else begin
      if (host_rd) m_rdata = rv;
      m_ack = host_rd | host_wr;
      if (host_wr && host_addr == 2'd1) m_pout = host_wdata;
      m_act = ((host_rd && host_addr == 2'd3) ? 32'h0 : m_act) | (c ? (probe_in ^ m_cap) : 32'h0);
      if (c) begin
        m_cap = probe_in;
        m_cnt = m_cnt + 16'd1;
      end
      if (m_n < 32'h4000_0000) m_n++;
    end
    chk("locked", locked, m_locked());
    chk("ce", ce, m_ce());
    chk("probe_out", probe_out, m_pout);
    chk("ack", ack, m_ack);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic host_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    host_rd = 1'b1; host_addr = a;
    tick();
    host_rd = 1'b0;
    chk(tag, rdata, exp);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [31:0] d);
    host_wr = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_wr = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce_edges[$];
    int exp_edges[3];
    int g, e;
    logic [15:0] c0;
    logic [31:0] bp;

    exp_edges[0] = 20; exp_edges[1] = 24; exp_edges[2] = 28;
    rst = 1; host_rd = 0; host_wr = 0; host_addr = 0; host_wdata = 0;
    probe_in = 32'h0000_00A5;
    b_rst = 1; b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_probe_in = 0;

    // Lock timing
    repeat (3) tick();
    rst = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (ce) ce_edges.push_back(i + 1);  // recorded as the edge that samples it
      if (i == 15) chk("lock_pre16", locked, 1'b0);
      if (i == 16) chk("lock_at16", locked, 1'b1);
    end
    chk("ce_count", ce_edges.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("ce_edge", (i < ce_edges.size()) ? ce_edges[i] : -1, exp_edges[i]);

    // Capture and count
    g = 0;
    while (m_cnt != 16'd5 && g < 100) begin tick(); g++; end
    chk("wait_cnt5", g < 100, 1'b1);
    host_read(2'd0, 32'h0000_00A5, "rd_cap");
    host_read(2'd2, 32'h8000_0005, "rd_stat");
    host_read(2'd3, 32'h0000_00A5, "rd_act");
    host_read(2'd3, 32'h0000_0000, "rd_act_cleared");

    // Probe out
    host_write(2'd1, 32'hDEAD_BEEF);
    chk("pout_wr", probe_out, 32'hDEAD_BEEF);
    host_read(2'd1, 32'hDEAD_BEEF, "rd_pout");
    host_write(2'd0, 32'h0000_1234);
    chk("ack_wr_ro", ack, 1'b1);
    host_read(2'd0, 32'h0000_00A5, "cap_unchanged");

    // Clear-on-read colliding with a capture
    probe_in = 32'h0;
    c0 = m_cnt; g = 0;
    while (m_cnt == c0 && g < 20) begin tick(); g++; end
    host_read(2'd3, 32'h0000_00A5, "act_pre");
    probe_in = 32'h1;
    g = 0;
    while (!m_ce() && g < 20) begin tick(); g++; end
    chk("wait_ce", g < 20, 1'b1);
    host_read(2'd3, 32'h0, "rd_collide_old");
    host_read(2'd3, 32'h1, "act_after_collide");

    // Randomized traffic against the model
    repeat (300) begin
      probe_in   = $urandom;
      host_rd    = 1'($urandom_range(0, 1));
      host_wr    = 1'($urandom_range(0, 1));
      host_addr  = 2'($urandom_range(0, 3));
      host_wdata = $urandom;
      tick();
    end
    host_rd = 0; host_wr = 0;

    // Mid-run reset with an in-flight read
    host_write(2'd1, 32'hDEAD_BEEF);
    chk("pout_before_rst", probe_out, 32'hDEAD_BEEF);
    rst = 1; host_rd = 1; host_addr = 2'd0;
    tick();
    chk("rst_locked", locked, 1'b0);
    chk("rst_ce", ce, 1'b0);
    chk("rst_pout", probe_out, INIT);
    chk("rst_ack", ack, 1'b0);
    rst = 0; host_rd = 0;
    host_read(2'd2, 32'h0, "stat_after_rst");
    e = 1;
    while (!locked && e < 40) begin tick(); e++; end
    chk("relock_edge", e, L);

    // DIV=1 instance: enable with lock, then 16-bit count wrap
    bp = $urandom;
    b_probe_in = bp;
    b_rst = 0;
    repeat (15) tick();
    chk("d1_lock_pre", b_locked, 1'b0);
    chk("d1_ce_pre", b_ce, 1'b0);
    tick();
    chk("d1_lock", b_locked, 1'b1);
    chk("d1_ce_with_lock", b_ce, 1'b1);
    repeat (65536) tick();
    b_rd = 1; b_addr = 2'd2;
    tick();
    b_rd = 0;
    chk("d1_cnt_wrap", b_rdata, 32'h8000_0000);
    chk("d1_ack", b_ack, 1'b1);
    b_rd = 1; b_addr = 2'd0;
    tick();
    b_rd = 0;
    chk("d1_cap", b_rdata, bp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
